rhd_scan_sequencer: RTL and testbench
=====================================

// Module: rhd_scan_sequencer
// PURPOSE
// - Frame-level controller for the RHD SPI master: on each sample_tick, issues CONVERT(0..N-1) plus two pipeline-flush commands.
// - Drives the SPI master start/data_in handshake and realigns the 2-command-late RHD replies to their channel.
// - Emits one tagged 32-bit result per channel on a valid/ready stream toward the sample buffer.
// PARAMETERS
// - MAX_CH     32      upper clamp for num_channels; sets the ch field width (6b)
// - FLUSH_CMD  16'hE800  flush command, READ(40); its reply is discarded
// PORTS
// - clk          in   1   system clock (SPI master's clk)
// - rst          in   1   asynchronous, active-high reset
// - enable       in   1   allow frames to start
// - sample_tick  in   1   1-cycle pulse; starts a frame when idle
// - num_channels in   6   channels per frame; captured at frame start
// - clear_flags  in   1   clears sticky flags
// - spi_start    out  1   start pulse to SPI master
// - spi_cmd      out  16  command to SPI master data_in
// - spi_done     in   1   SPI master done (multi-cycle level)
// - spi_data     in   32  SPI master data_out (MISO A/B, DDR)
// - res_valid    out  1   result valid
// - res_ready    in   1   consumer accepts result
// - res_channel  out  6   channel of res_data
// - res_data     out  32  reply word for res_channel
// - frame_done   out  1   1-cycle pulse after last command completes
// - seq_busy     out  1   high from frame start to frame_done
// - tick_miss    out  1   sticky: sample_tick seen while seq_busy
// - res_overrun  out  1   sticky: new result overwrote an unaccepted one
// BEHAVIOUR
// - Reset (async): state IDLE; every output 0; spi_cmd=0.
// - FSM: IDLE -> ISSUE -> WAIT_DONE -> WAIT_REL -> (ISSUE | FINISH); FINISH -> IDLE.
// - IDLE: sample_tick & enable -> latch N (0->1, >MAX_CH->MAX_CH); idx=0; L=N+2 (+1 with AUX_CMD_EN).
// - Command at idx: idx<N -> {2'b00,idx[5:0],8'h00}; then AUX slot if enabled; last two -> FLUSH_CMD.
// - ISSUE: spi_start=1 for exactly one cycle; spi_cmd set here and held until WAIT_REL exits.
// - WAIT_DONE: first cycle spi_done=1 -> capture spi_data as reply of command idx-2 (if idx>=2).
// - Reply tag: idx-2<N -> result for channel idx-2; AUX reply -> aux_rdata; else discarded.
// - WAIT_REL: wait spi_done=0; idx++; idx==L -> FINISH, else ISSUE. No timeout.
// - FINISH: frame_done=1 one cycle, seq_busy drops same edge, back to IDLE.
// - Result reg: capture sets res_valid; cleared on res_valid&res_ready.
// - Capture while res_valid&!res_ready: data/channel overwritten, res_overrun set.
// - Capture coinciding with accept: no overrun; new result loaded.
// - sample_tick while seq_busy: ignored, tick_miss set. clear_flags & new event same cycle: flag set.
// - enable low mid-frame: frame completes; no new frame starts.
// - num_channels change mid-frame: no effect until next frame.
// - Latency: tick -> spi_start 1 cycle; spi_done rise -> res_valid 1 cycle.
// CONFIGURATION
// - AUX_CMD_EN defined: extra ports aux_cmd[15:0] in, aux_rdata[31:0] out, aux_rvalid out (1-cycle).
// - With AUX_CMD_EN: aux_cmd sampled at frame start, issued after CONVERT(N-1); L=N+3.
// - With AUX_CMD_EN: reply emitted on aux_rdata/aux_rvalid, not on the res stream.
// - AUX_CMD_EN undefined: no aux ports; L=N+2.
// STRUCTURE
// - Package rhd_pkg: FSM state enum; CMD_CONVERT/READ/WRITE opcode constants.
// - Package rhd_pkg: FLUSH_CMD default; PIPE_DEPTH=2; function convert_cmd(ch).
// - Sub-module rhd_result_slot: one-entry valid/ready register with overwrite/overrun detect.
// TESTING
// - N=4, res_ready=1, model done 20 cycles after start -> 6 starts.
// -   N=4 cmds: 0x0000,0x0100,0x0200,0x0300,0xE800,0xE800; results ch0..3 match model replies 2..5; one frame_done.
// - N=0 -> 3 commands; one result, ch0. N=40 -> clamped, 34 commands, ch0..31.
// - res_ready=0 whole frame, N=3 -> res_overrun=1; res_data=reply for ch2, res_channel=2.
// - Second sample_tick 10 cycles after first -> tick_miss=1, still only one frame.
// -   clear_flags afterwards -> tick_miss=0.
// - rst asserted in WAIT_DONE -> spi_start, res_valid, seq_busy=0 immediately.
// -   Next tick after rst release -> new frame restarts at CONVERT(0).
// - AUX_CMD_EN, aux_cmd=0x8000, N=2 -> cmds 0x0000,0x0100,0x8000,0xE800,0xE800.
// -   Same case: aux_rvalid pulses once with 5th reply; only 2 res results.

Source files
------------

// File: rtl/rhd_pkg.sv
// rtl/rhd_pkg.sv - Shared types and RHD command encodings for the scan sequencer.
package rhd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_WAIT_REL,
    ST_FINISH
  } seq_state_t;

  localparam logic [1:0] CMD_CONVERT = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_READ    = 2'b11;

  // READ(40): harmless register read used to push the last two replies out.
  localparam logic [15:0] FLUSH_CMD_DEFAULT = {CMD_READ, 6'd40, 8'h00};

  // Replies arrive two commands after the command that produced them.
  localparam int PIPE_DEPTH = 2;

  function automatic logic [15:0] convert_cmd(input logic [5:0] ch);
    return {CMD_CONVERT, ch, 8'h00};
  endfunction

endpackage

// File: rtl/rhd_result_slot.sv
// rtl/rhd_result_slot.sv - One-entry valid/ready result register with sticky overrun flag.
module rhd_result_slot #(
  parameter int CW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_channel,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  input  logic          clear_flag,
  output logic          valid,
  output logic [CW-1:0] channel,
  output logic [DW-1:0] data,
  output logic          overrun
);

  logic lost;

  // A load on the accept cycle is a clean hand-over, not a loss.
  assign lost = load && valid && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      channel <= '0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        valid   <= 1'b1;
        channel <= load_channel;
        data    <= load_data;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      overrun <= (overrun && !clear_flag) || lost;
    end
  end

endmodule

// File: rtl/rhd_scan_sequencer.sv
// rtl/rhd_scan_sequencer.sv - Per-tick CONVERT sweep plus flushes, with 2-deep reply realignment.
// Define AUX_CMD_EN to add one user command slot after the sweep, reported on aux_rdata/aux_rvalid.
module rhd_scan_sequencer
  import rhd_pkg::*;
#(
  parameter int          MAX_CH    = 32,
  parameter logic [15:0] FLUSH_CMD = FLUSH_CMD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_tick,
  input  logic [5:0]  num_channels,
  input  logic        clear_flags,
  output logic        spi_start,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [31:0] spi_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [5:0]  res_channel,
  output logic [31:0] res_data,
  output logic        frame_done,
  output logic        seq_busy,
  output logic        tick_miss,
`ifdef AUX_CMD_EN
  input  logic [15:0] aux_cmd,
  output logic [31:0] aux_rdata,
  output logic        aux_rvalid,
`endif
  output logic        res_overrun
);

`ifdef AUX_CMD_EN
  localparam int AUX_SLOTS = 1;
`else
  localparam int AUX_SLOTS = 0;
`endif
  localparam logic [5:0] MAX_N     = 6'(MAX_CH);
  localparam logic [5:0] PIPE_W    = 6'(PIPE_DEPTH);
  localparam logic [5:0] LEN_EXTRA = 6'(PIPE_DEPTH + AUX_SLOTS);

  seq_state_t  state, state_d;
  logic [5:0]  idx, idx_d, idx_inc;
  logic [5:0]  n_lat, n_d, n_clamped;
  logic [5:0]  len, len_d;
  logic [5:0]  rep_idx;
  logic [15:0] cmd_d, nxt_cmd;
  logic        frame_start, capture, have_rep, res_load;

  assign frame_start = (state == ST_IDLE) && sample_tick && enable;
  assign idx_inc     = idx + 6'd1;
  assign rep_idx     = idx - PIPE_W;
  assign have_rep    = (idx >= PIPE_W);
  assign res_load    = capture && have_rep && (rep_idx < n_lat);

  always_comb begin
    n_clamped = num_channels;
    if (num_channels == 6'd0) begin
      n_clamped = 6'd1;
    end else if (num_channels > MAX_N) begin
      n_clamped = MAX_N;
    end
  end

`ifdef AUX_CMD_EN
  logic [15:0] aux_lat;
  logic        aux_load;

  assign aux_load = capture && have_rep && (rep_idx == n_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_lat    <= '0;
      aux_rdata  <= '0;
      aux_rvalid <= 1'b0;
    end else begin
      if (frame_start) begin
        aux_lat <= aux_cmd;
      end
      aux_rvalid <= aux_load;
      if (aux_load) begin
        aux_rdata <= spi_data;
      end
    end
  end
`endif

  // Command for the slot after the current one: CONVERTs, optional AUX, then flushes.
  always_comb begin
    nxt_cmd = FLUSH_CMD;
    if (idx_inc < n_lat) begin
      nxt_cmd = convert_cmd(idx_inc);
    end
`ifdef AUX_CMD_EN
    else if (idx_inc == n_lat) begin
      nxt_cmd = aux_lat;
    end
`endif
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    n_d        = n_lat;
    len_d      = len;
    cmd_d      = spi_cmd;
    capture    = 1'b0;
    spi_start  = 1'b0;
    frame_done = 1'b0;
    seq_busy   = (state != ST_IDLE) && (state != ST_FINISH);
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          n_d     = n_clamped;
          len_d   = n_clamped + LEN_EXTRA;
          idx_d   = 6'd0;
          cmd_d   = convert_cmd(6'd0);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        spi_start = 1'b1;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (spi_done) begin
          capture = 1'b1;
          state_d = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!spi_done) begin
          idx_d = idx_inc;
          if (idx_inc == len) begin
            state_d = ST_FINISH;
          end else begin
            cmd_d   = nxt_cmd;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      n_lat     <= '0;
      len       <= '0;
      spi_cmd   <= '0;
      tick_miss <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      n_lat     <= n_d;
      len       <= len_d;
      spi_cmd   <= cmd_d;
      tick_miss <= (tick_miss && !clear_flags) || (sample_tick && (state != ST_IDLE));
    end
  end

  rhd_result_slot #(
    .CW(6),
    .DW(32)
  ) u_slot (
    .clk          (clk),
    .rst          (rst),
    .load         (res_load),
    .load_channel (rep_idx),
    .load_data    (spi_data),
    .ready        (res_ready),
    .clear_flag   (clear_flags),
    .valid        (res_valid),
    .channel      (res_channel),
    .data         (res_data),
    .overrun      (res_overrun)
  );

endmodule

// File: tb/tb_rhd_scan_sequencer.sv
// tb/tb_rhd_scan_sequencer.sv - Self-checking bench: table vectors, random frames, corner sequences.
module tb_rhd_scan_sequencer;

`ifdef AUX_CMD_EN
  localparam int AUX_EXTRA = 1;
`else
  localparam int AUX_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        sample_tick = 1'b0;
  logic [5:0]  num_channels = '0;
  logic        clear_flags = 1'b0;
  logic        spi_start;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [31:0] spi_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [5:0]  res_channel;
  logic [31:0] res_data;
  logic        frame_done;
  logic        seq_busy;
  logic        tick_miss;
  logic        res_overrun;
  logic [15:0] aux_val = '0;
`ifdef AUX_CMD_EN
  logic [31:0] aux_rdata;
  logic        aux_rvalid;
  int          aux_count = 0;
  logic [31:0] aux_last = '0;
`endif

  always #5 clk = ~clk;

  rhd_scan_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .num_channels (num_channels),
    .clear_flags  (clear_flags),
    .spi_start    (spi_start),
    .spi_cmd      (spi_cmd),
    .spi_done     (spi_done),
    .spi_data     (spi_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_channel  (res_channel),
    .res_data     (res_data),
    .frame_done   (frame_done),
    .seq_busy     (seq_busy),
    .tick_miss    (tick_miss),
`ifdef AUX_CMD_EN
    .aux_cmd      (aux_val),
    .aux_rdata    (aux_rdata),
    .aux_rvalid   (aux_rvalid),
`endif
    .res_overrun  (res_overrun)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] cmd_q[$];
  logic [31:0] reply_q[$];
  logic [5:0]  rch_q[$];
  logic [31:0] rdat_q[$];
  int          start_cycles = 0;
  int          fd_count = 0;
  int          done_dly = 2;
  int          done_hold = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // SPI master stand-in: one random reply word per command, delivered after done_dly cycles.
  initial begin
    logic [31:0] w;
    spi_done = 1'b0;
    spi_data = '0;
    forever begin
      @(negedge clk);
      if (spi_start && !rst) begin
        w = $urandom;
        cmd_q.push_back(spi_cmd);
        reply_q.push_back(w);
        for (int i = 0; i < done_dly && !rst; i++) @(negedge clk);
        if (!rst) begin
          spi_done = 1'b1;
          spi_data = w;
          for (int i = 0; i < done_hold && !rst; i++) @(negedge clk);
        end
        spi_done = 1'b0;
        spi_data = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_start) start_cycles++;
      if (frame_done) fd_count++;
      if (res_valid && res_ready) begin
        rch_q.push_back(res_channel);
        rdat_q.push_back(res_data);
      end
`ifdef AUX_CMD_EN
      if (aux_rvalid) begin
        aux_count++;
        aux_last = aux_rdata;
      end
`endif
    end
  end

  function automatic int ref_neff(input int n);
    return (n == 0) ? 1 : ((n > 32) ? 32 : n);
  endfunction

  task automatic start_frame(input int n, input bit rdy, output int bc, output int br,
                             output int bs, output int bf);
    @(negedge clk);
    bc = cmd_q.size();
    br = rch_q.size();
    bs = start_cycles;
    bf = fd_count;
    num_channels = 6'(n);
    res_ready = rdy;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("tick_to_start", {31'd0, spi_start}, 32'd1);
  endtask

  task automatic wait_frame(input int bf);
    for (int c = 0; c < 5000 && fd_count <= bf; c++) @(negedge clk);
    chk("frame_done_seen", {31'd0, fd_count > bf}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int exp_neff, input int exp_len,
                             input int bc, input int br, input int bs, input int bf,
                             input bit rdy);
    int len;
    int nc;
    int nr;
    logic [15:0] e;
    len = exp_len + AUX_EXTRA;
    nc = cmd_q.size() - bc;
    chk({tag, " starts"}, 32'(start_cycles - bs), 32'(len));
    chk({tag, " cmd_count"}, 32'(nc), 32'(len));
    for (int i = 0; i < len && i < nc; i++) begin
      if (i < exp_neff) e = {2'b00, 6'(i), 8'h00};
      else if (AUX_EXTRA == 1 && i == exp_neff) e = aux_val;
      else e = 16'hE800;
      chk($sformatf("%s cmd[%0d]", tag, i), 32'(cmd_q[bc+i]), 32'(e));
    end
    chk({tag, " frame_done_count"}, 32'(fd_count - bf), 32'd1);
    if (rdy) begin
      nr = rch_q.size() - br;
      chk({tag, " res_count"}, 32'(nr), 32'(exp_neff));
      for (int i = 0; i < exp_neff && i < nr; i++) begin
        chk($sformatf("%s res_ch[%0d]", tag, i), 32'(rch_q[br+i]), 32'(i));
        chk($sformatf("%s res_data[%0d]", tag, i), rdat_q[br+i], reply_q[bc+i+2]);
      end
    end
  endtask

  typedef struct {
    int n;
    int dly;
    int hold;
    int exp_neff;
    int exp_len;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int bc, br, bs, bf, n;

    tbl[0] = '{4, 20, 3, 4, 6};
    tbl[1] = '{0, 2, 1, 1, 3};
    tbl[2] = '{40, 1, 1, 32, 34};
    tbl[3] = '{7, 3, 2, 7, 9};

    repeat (3) @(negedge clk);
    chk("rst spi_start", {31'd0, spi_start}, 32'd0);
    chk("rst spi_cmd", 32'(spi_cmd), 32'd0);
    chk("rst res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst seq_busy", {31'd0, seq_busy}, 32'd0);
    chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst flags", {30'd0, tick_miss, res_overrun}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    enable = 1'b0;
    bs = start_cycles;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("disabled busy", {31'd0, seq_busy}, 32'd0);
    chk("disabled starts", 32'(start_cycles - bs), 32'd0);
    enable = 1'b1;

    for (int t = 0; t < 4; t++) begin
      done_dly = tbl[t].dly;
      done_hold = tbl[t].hold;
      aux_val = 16'h8000 | 16'(t);
      start_frame(tbl[t].n, 1'b1, bc, br, bs, bf);
      wait_frame(bf);
      check_frame($sformatf("vec%0d", t), tbl[t].exp_neff, tbl[t].exp_len, bc, br, bs, bf, 1'b1);
    end

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 40);
      done_dly = $urandom_range(1, 4);
      done_hold = $urandom_range(1, 3);
      aux_val = 16'($urandom);
      start_frame(n, 1'b1, bc, br, bs, bf);
      wait_frame(bf);
      check_frame($sformatf("rnd%0d_n%0d", r, n), ref_neff(n), ref_neff(n) + 2, bc, br, bs, bf, 1'b1);
    end

    done_dly = 2;
    done_hold = 1;
    start_frame(3, 1'b0, bc, br, bs, bf);
    wait_frame(bf);
    check_frame("ovr", 3, 5, bc, br, bs, bf, 1'b0);
    chk("ovr res_overrun", {31'd0, res_overrun}, 32'd1);
    chk("ovr res_valid", {31'd0, res_valid}, 32'd1);
    chk("ovr res_channel", 32'(res_channel), 32'd2);
    chk("ovr res_data", res_data, reply_q[bc+4]);
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("ovr cleared", {31'd0, res_overrun}, 32'd0);
    chk("ovr drained", {31'd0, res_valid}, 32'd0);

    start_frame(3, 1'b1, bc, br, bs, bf);
    num_channels = 6'd9;
    repeat (8) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    wait_frame(bf);
    repeat (3) @(negedge clk);
    check_frame("miss", 3, 5, bc, br, bs, bf, 1'b1);
    chk("miss tick_miss", {31'd0, tick_miss}, 32'd1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    @(negedge clk);
    chk("miss cleared", {31'd0, tick_miss}, 32'd0);

    done_dly = 20;
    done_hold = 2;
    start_frame(4, 1'b0, bc, br, bs, bf);
    for (int c = 0; c < 2000 && start_cycles < bs + 4; c++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("mid res_valid", {31'd0, res_valid}, 32'd1);
    chk("mid seq_busy", {31'd0, seq_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async spi_start", {31'd0, spi_start}, 32'd0);
    chk("async res_valid", {31'd0, res_valid}, 32'd0);
    chk("async seq_busy", {31'd0, seq_busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    done_dly = 2;
    done_hold = 1;
    repeat (3) @(negedge clk);
    start_frame(2, 1'b1, bc, br, bs, bf);
    wait_frame(bf);
    check_frame("post_rst", 2, 4, bc, br, bs, bf, 1'b1);

`ifdef AUX_CMD_EN
    begin
      int ba;
      aux_val = 16'h8000;
      ba = aux_count;
      start_frame(2, 1'b1, bc, br, bs, bf);
      wait_frame(bf);
      check_frame("aux", 2, 4, bc, br, bs, bf, 1'b1);
      chk("aux rvalid count", 32'(aux_count - ba), 32'd1);
      chk("aux rdata", aux_last, reply_q[bc+4]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

endmodule
